// File: rtl/seq_fsmd_acc.sv
// Serial pattern detector whose matches drive a small accumulator datapath.
// Define SEQ_FSMD_CNT_EN to build the saturating match counter; otherwise match_cnt reads zero.
module seq_fsmd_acc #(
    parameter int               DATA_W  = 16,
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
    parameter int               OVERLAP = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              d_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] data_out,
    output logic              match,
    output logic [7:0]        match_cnt
);

    localparam int               CNT_W     = $clog2(PAT_W + 1);
    localparam logic [CNT_W-1:0] FCNT_FULL = CNT_W'(PAT_W);
    localparam logic [CNT_W-1:0] FCNT_SCAN = CNT_W'(PAT_W - 1);

    typedef enum logic {
        FILL,
        SCAN
    } state_t;

    typedef enum logic [1:0] {
        MODE_LOAD = 2'b00,
        MODE_ADD  = 2'b01,
        MODE_XOR  = 2'b10,
        MODE_MAX  = 2'b11
    } mode_t;

    state_t            state;
    state_t            next_state;
    logic [PAT_W-1:0]  hist;
    logic [PAT_W-1:0]  window;
    logic [CNT_W-1:0]  fcnt;
    logic [CNT_W-1:0]  fcnt_next;
    logic              hit;
    logic [DATA_W-1:0] data_next;

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: the fill count decides whether a full window is available.
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        window    = PAT_W'({hist, d_in});
        hit       = en && (state == SCAN) && (window == PATTERN);
        fcnt_next = fcnt;
        if (en) begin
            if (hit && (OVERLAP == 0)) begin
                fcnt_next = '0;
            end else if (fcnt != FCNT_FULL) begin
                fcnt_next = fcnt + CNT_W'(1);
            end
        end
        next_state = (fcnt_next >= FCNT_SCAN) ? SCAN : FILL;
    end

    // Output logic: the accumulator result a hit would commit.
    always_comb begin
        data_next = data_out;
        unique case (mode_t'(mode))
            MODE_LOAD: data_next = data_in;
            MODE_ADD:  data_next = data_out + data_in;
            MODE_XOR:  data_next = data_out ^ data_in;
            MODE_MAX:  data_next = (data_in > data_out) ? data_in : data_out;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist     <= '0;
            fcnt     <= '0;
            data_out <= '0;
            match    <= 1'b0;
        end else begin
            match <= hit;
            if (en) begin
                hist <= window;
                fcnt <= fcnt_next;
            end
            if (hit) begin
                data_out <= data_next;
            end
        end
    end

`ifdef SEQ_FSMD_CNT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (hit && (cnt_q != 8'hFF)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_seq_fsmd_acc.sv
// Bench for seq_fsmd_acc: an overlapping and a non-overlapping instance share one stimulus
// stream and are compared each cycle against a bit-stream reference model.
module tb_seq_fsmd_acc;

    localparam int         DATA_W  = 16;
    localparam int         PAT_W   = 4;
    localparam logic [3:0] PATTERN = 4'b1010;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic              d_in;
    logic [DATA_W-1:0] data_in;
    logic [1:0]        mode;

    logic [DATA_W-1:0] data_out_ov, data_out_no;
    logic              match_ov, match_no;
    logic [7:0]        match_cnt_ov, match_cnt_no;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: every enabled bit since reset, plus where each instance's fresh bits start.
    bit          stream[$];
    int          start_idx[2];
    logic [15:0] m_data[2];
    int          m_cnt[2];
    bit          m_match[2];

    always #5 clk = ~clk;

    seq_fsmd_acc #(.DATA_W(DATA_W), .PAT_W(PAT_W), .PATTERN(PATTERN), .OVERLAP(1)) dut_ov (
        .clk(clk), .reset(reset), .en(en), .d_in(d_in), .data_in(data_in), .mode(mode),
        .data_out(data_out_ov), .match(match_ov), .match_cnt(match_cnt_ov)
    );

    seq_fsmd_acc #(.DATA_W(DATA_W), .PAT_W(PAT_W), .PATTERN(PATTERN), .OVERLAP(0)) dut_no (
        .clk(clk), .reset(reset), .en(en), .d_in(d_in), .data_in(data_in), .mode(mode),
        .data_out(data_out_no), .match(match_no), .match_cnt(match_cnt_no)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit window_hits(input int i);
        logic [PAT_W-1:0] val;
        int               n;
        n   = stream.size();
        val = '0;
        if (n - start_idx[i] < PAT_W) return 1'b0;
        for (int k = 0; k < PAT_W; k++) val = {val[PAT_W-2:0], stream[n-PAT_W+k]};
        return val == PATTERN;
    endfunction

    function automatic logic [7:0] exp_cnt(input int i);
`ifdef SEQ_FSMD_CNT_EN
        return 8'(m_cnt[i]);
`else
        return 8'h00 | 8'(i & 0);
`endif
    endfunction

    task automatic step(input bit rst, input bit e, input bit d,
                        input logic [15:0] di, input logic [1:0] md);
        reset = rst; en = e; d_in = d; data_in = di; mode = md;
        if (rst) begin
            stream.delete();
            for (int i = 0; i < 2; i++) begin
                start_idx[i] = 0; m_data[i] = '0; m_cnt[i] = 0; m_match[i] = 1'b0;
            end
        end else if (e) begin
            stream.push_back(d);
            for (int i = 0; i < 2; i++) begin
                m_match[i] = window_hits(i);
                if (m_match[i]) begin
                    case (md)
                        2'b00: m_data[i] = di;
                        2'b01: m_data[i] = 16'((32'(m_data[i]) + 32'(di)) % 65536);
                        2'b10: m_data[i] = m_data[i] ^ di;
                        default: m_data[i] = (di > m_data[i]) ? di : m_data[i];
                    endcase
                    if (m_cnt[i] < 255) m_cnt[i]++;
                    if (i == 1) start_idx[1] = stream.size();
                end
            end
        end else begin
            m_match[0] = 1'b0; m_match[1] = 1'b0;
        end
        @(posedge clk);
        #1;
        check("match_ov", 32'(match_ov), 32'(m_match[0]));
        check("match_no", 32'(match_no), 32'(m_match[1]));
        check("data_ov", 32'(data_out_ov), 32'(m_data[0]));
        check("data_no", 32'(data_out_no), 32'(m_data[1]));
        check("cnt_ov", 32'(match_cnt_ov), 32'(exp_cnt(0)));
        check("cnt_no", 32'(match_cnt_no), 32'(exp_cnt(1)));
    endtask

    // One enabled bit with junk operands, so non-hit cycles prove mode/data_in are ignored.
    task automatic bit_in(input bit d);
        step(1'b0, 1'b1, d, 16'($urandom), 2'($urandom));
    endtask

    task automatic bit_op(input bit d, input logic [15:0] di, input logic [1:0] md);
        step(1'b0, 1'b1, d, di, md);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b1, 16'hBEEF, 2'b01);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; d_in = 1'b0; data_in = '0; mode = '0;

        // Reset held two cycles, then overlapping load sequence.
        do_reset();
        do_reset();
        check("rst_data", 32'(data_out_ov), 32'h0);
        bit_in(1); bit_in(0); bit_in(1);
        bit_op(0, 16'h00AA, 2'b00);
        check("r031_first", 32'(data_out_ov), 32'h00AA);
        bit_in(1);
        bit_op(0, 16'h0055, 2'b00);
        check("r031_second", 32'(data_out_ov), 32'h0055);
`ifdef SEQ_FSMD_CNT_EN
        check("r031_cnt", 32'(match_cnt_ov), 32'd2);
`else
        check("r031_cnt", 32'(match_cnt_ov), 32'd0);
`endif

        // Non-overlap: 10101010 matches only after bits 4 and 8.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            bit_in(k[0] == 1'b0);
            if (k == 3 || k == 7) check("r032_hit", 32'(match_no), 32'd1);
        end

        // Arithmetic wrap through all four modes.
        do_reset();
        bit_in(1); bit_in(0); bit_in(1);
        bit_op(0, 16'hFFFF, 2'b00);
        bit_in(1);
        bit_op(0, 16'h0002, 2'b01);
        check("r033_add", 32'(data_out_ov), 32'h0001);
        bit_in(1);
        bit_op(0, 16'h0003, 2'b10);
        check("r033_xor", 32'(data_out_ov), 32'h0002);
        bit_in(1);
        bit_op(0, 16'h0001, 2'b11);
        check("r033_max", 32'(data_out_ov), 32'h0002);

        // Enable gap holds the partial pattern.
        do_reset();
        bit_in(1); bit_in(0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 16'($urandom), 2'($urandom));
        bit_in(1); bit_in(0);
        check("r034_match", 32'(match_ov), 32'd1);

        // Reset discards a partial pattern.
        do_reset();
        bit_in(1); bit_in(0); bit_in(1);
        do_reset();
        bit_in(0);
        check("r035_none", 32'(match_ov), 32'd0);
        bit_in(1); bit_in(0); bit_in(1); bit_in(0);
        check("r035_match", 32'(match_ov), 32'd1);

        // 300 overlapping hits saturate the counter.
        do_reset();
        for (int k = 0; k < 602; k++) bit_in(k[0] == 1'b0);
`ifdef SEQ_FSMD_CNT_EN
        check("r036_sat", 32'(match_cnt_ov), 32'hFF);
`else
        check("r036_sat", 32'(match_cnt_ov), 32'h00);
`endif

        // Random traffic with occasional enable gaps and resets.
        do_reset();
        for (int k = 0; k < 500; k++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                 16'($urandom), 2'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_fsmd_acc.md
SEQ_FSMD_ACC -- requirements
Module: seq_fsmd_acc

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath width in bits.
REQ-002 SHALL have parameter PAT_W, default 4, detected pattern length in bits (2..16).
REQ-003 SHALL have parameter PATTERN, default 4'b1010, target sequence; MSB is the oldest bit.
REQ-004 SHALL have parameter OVERLAP, default 1; 1 means overlapping detection, 0 means non-overlapping.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port en  input  1  sample enable; when low, the block holds all state.
REQ-008 SHALL have port d_in  input  1  serial bit stream, one bit per enabled clock.
REQ-009 SHALL have port data_in  input  DATA_W  operand applied on match.
REQ-010 SHALL have port mode  input  2  match action: 00 load, 01 add, 10 xor, 11 max.
REQ-011 SHALL have port data_out  output  DATA_W  registered result.
REQ-012 SHALL have port match  output  1  registered one-cycle pulse per detection.
REQ-013 SHALL have port match_cnt  output  8  registered saturating detection count.

Function
REQ-014 SHALL keep a PAT_W-bit history register hist and a fill counter fcnt (0..PAT_W).
REQ-015 SHALL implement FSM states FILL (fcnt<PAT_W-1) and SCAN (fcnt>=PAT_W-1); reset enters FILL.
REQ-016 On a rising edge with en=1: hist <= {hist[PAT_W-2:0], d_in}; fcnt increments and saturates at PAT_W.
REQ-017 SHALL define hit as en=1, state SCAN, and {hist[PAT_W-2:0], d_in}==PATTERN, all evaluated at the same edge.
REQ-018 On hit, match SHALL be 1 for exactly the following cycle, i.e. latency is one clock from the sampling edge of the last pattern bit.
REQ-019 On hit with OVERLAP=0, fcnt SHALL clear to 0 (FSM returns to FILL), so PAT_W fresh bits are required before the next match.
REQ-020 On hit with OVERLAP=1, fcnt SHALL remain saturated, allowing pattern suffix/prefix reuse.
REQ-021 On hit, data_out SHALL update using data_in sampled at the same edge: 00 -> data_in; 01 -> (data_out+data_in) mod 2^DATA_W; 10 -> data_out^data_in; 11 -> unsigned max(data_out, data_in).
REQ-022 Without a hit, data_out SHALL hold its value; match SHALL be 0.
REQ-023 When en=0: hist, fcnt, FSM state, data_out and match_cnt SHALL hold, and match SHALL be 0.
REQ-024 mode and data_in SHALL be ignored on cycles without a hit.

Reset
REQ-025 With reset=1 at a rising edge: hist=0, fcnt=0, state=FILL, data_out=0, match=0, match_cnt=0.
REQ-026 reset SHALL take priority over en and hit at the same edge.
REQ-027 A partial pattern in progress when reset asserts SHALL be discarded.

Configuration
REQ-028 SHALL use macro SEQ_FSMD_CNT_EN to control the detection counter.
REQ-029 With SEQ_FSMD_CNT_EN defined, match_cnt SHALL increment on each hit and saturate at 8'hFF.
REQ-030 Without SEQ_FSMD_CNT_EN, match_cnt SHALL be tied to 8'h00, and no counter register SHALL be synthesised.

Verification (defaults DATA_W=16, PAT_W=4, PATTERN=1010, en=1 unless stated)
REQ-031 Reset/overlap: hold reset 2 cycles -> all outputs 0. Then, mode=00, OVERLAP=1, feed d_in 1,0,1,0,1,0 with data_in=16'h00AA on bit 4 and 16'h0055 on bit 6 -> match pulses after bits 4 and 6; data_out=16'h00AA, then 16'h0055; match_cnt=2.
REQ-032 Non-overlap: OVERLAP=0, feed 1,0,1,0,1,0,1,0 -> match only after bits 4 and 8.
REQ-033 Arithmetic wrap: mode=00 hit with 16'hFFFF, then mode=01 hit with 16'h0002 -> data_out=16'h0001. Next, mode=10 hit with 16'h0003 -> data_out=16'h0002. Next, mode=11 hit with 16'h0001 -> data_out=16'h0002.
REQ-034 Enable gap: feed 1,0, then 3 cycles en=0 with d_in=1, then 1,0 -> single match after the final 0, with no match during the en=0 cycles.
REQ-035 Reset mid-operation: feed 1,0,1, assert reset one cycle, then feed 0 -> no match; feed 1,0,1,0 -> match.
REQ-036 Counter saturation: 300 overlapping hits -> match_cnt=8'hFF with SEQ_FSMD_CNT_EN defined; match_cnt=8'h00 without it.
